// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: master issues operands, slave returns results.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_trial_sub.sv
// One restoring-division trial: (WIDTH+1)-bit subtract reporting the borrow out.
module trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_CHK_EN to short-cut a zero divisor straight to DONE with div_by_zero set.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zf_q, zf_d;
    logic             dbz_q, dbz_d;

    logic             zero_skip;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;

`ifdef DIV_ZERO_CHK_EN
    assign zero_skip = (bus.divisor == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Partial remainder is kept WIDTH bits wide; the trial itself runs at WIDTH+1.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dvs_q}),
        .diff       (diff),
        .borrow     (borrow)
    );

    // A successful trial is always below the divisor, so the top difference bit is never kept.
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        zf_d    = zf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    zf_d    = zero_skip;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (zf_q) begin
                    state_d = DONE;
                end else begin
                    // dvd_q doubles as the quotient shift register: dividend bits leave at the top.
                    rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                dbz_d   = zf_q;
                quo_d   = zf_q ? '1 : dvd_q;
                rmd_d   = zf_q ? dvd_q : rem_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            zf_q    <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            zf_q    <= zf_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;

endmodule
